rbcp_arbiter: RTL and testbench
===============================

RBCP_ARBITER -- requirements
Module: rbcp_arbiter

Interface
REQ-001 The block SHALL have one clock, CLK; reset RST is synchronous and active-high.
REQ-002 Parameters SHALL be:
- SEL_LSB, 24: LSB of the 2-bit slave-select field.
- TIMEOUT, 8'd255: maximum WAIT cycles before the block self-acknowledges.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK in 1: system clock (200 MHz domain).
- RST in 1: sync active-high reset.
- RBCP_ADDR in 32: host address.
- RBCP_WD in 8: host write data.
- RBCP_WE in 1: write strobe, 1-cycle pulse.
- RBCP_RE in 1: read strobe, 1-cycle pulse.
- RBCP_ACK out 1: access acknowledge, 1-cycle pulse.
- RBCP_RD out 8: read data, valid with RBCP_ACK.
- SLV_ADDR out 32: latched RBCP_ADDR.
- SLV_WD out 8: latched RBCP_WD.
- SLV_WE out 4: per-slave write strobe, one-hot.
- SLV_RE out 4: per-slave read strobe, one-hot.
- SLV_ACK in 4: per-slave acknowledge.
- SLV_RD in 32: slave i read data on bits [8i+7:8i].
- BUSY out 1: transaction in progress.
- ERR out 1: 1-cycle pulse on an unmapped access or a timeout.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; BUSY=1 in every state except IDLE.
REQ-005 In IDLE, on RBCP_WE|RBCP_RE the block SHALL latch address, write data, direction (WE has priority when both are high) and sel=RBCP_ADDR[SEL_LSB+1:SEL_LSB].
- RBCP_ADDR[31:SEL_LSB+2] nonzero: the access is unmapped; go to RESP with RD=8'h00 and ERR pulse.
- Otherwise: go to ISSUE.
REQ-006 In ISSUE, SLV_WE[sel] or SLV_RE[sel] SHALL be high for exactly one cycle, the timer SHALL load TIMEOUT, and the FSM SHALL go to WAIT.
REQ-007 In WAIT:
- SLV_ACK[sel]=1: capture SLV_RD byte sel (0x00 for writes), go to RESP.
- Timer reaches 0 without an acknowledge: RD=8'h00, ERR pulse, go to RESP.
- Otherwise: decrement the timer.
REQ-008 An acknowledge and timer expiry in the same cycle SHALL resolve as a normal acknowledge, with no ERR.
REQ-009 SLV_ACK bits of unselected slaves SHALL be ignored in all states.
REQ-010 In RESP, RBCP_ACK SHALL be 1 for one cycle with RBCP_RD valid, then the FSM SHALL go to IDLE; RBCP_RD SHALL hold its value until the next RESP.
REQ-011 RBCP_WE/RBCP_RE arriving outside IDLE SHALL be dropped: no latch, no ACK.
REQ-012 Latency: strobe sampled at edge n gives slave strobe in cycle n+1; slave ACK sampled at edge m gives RBCP_ACK in cycle m+1; an unmapped access gives RBCP_ACK in cycle n+1.
REQ-013 SLV_ADDR/SLV_WD SHALL be stable from ISSUE through RESP.

Reset
REQ-014 RST SHALL force IDLE; RBCP_ACK, SLV_WE, SLV_RE, BUSY and ERR to 0; and RBCP_RD, SLV_ADDR, SLV_WD and the timer to 0.
REQ-015 RST during any non-IDLE state SHALL abort the transaction with no RBCP_ACK and no ERR.

Configuration
REQ-016 With macro RBCP_ARB_TIMEOUT_EN defined, the timer and timeout path (REQ-007/008) SHALL be compiled in.
REQ-017 Without RBCP_ARB_TIMEOUT_EN, WAIT SHALL exit only on SLV_ACK[sel], TIMEOUT SHALL be unused, and ERR SHALL fire only on unmapped accesses.

Structure
REQ-018 Package rbcp_arb_pkg SHALL hold:
- the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
- NUM_SLV=4;
- the unmapped read value 8'h00.
REQ-019 The timer SHALL be sub-module rbcp_arb_timer (load, decrement, zero flag), instantiated only under RBCP_ARB_TIMEOUT_EN.

Verification
REQ-020 Write to addr 0x0100_0010, WD 0x5A; slave 1 acks 2 cycles after its strobe:
- SLV_WE=4'b0010 for one cycle, SLV_WD=0x5A;
- RBCP_ACK one cycle after the slave ACK; ERR=0.
REQ-021 Read addr 0x0300_0000 with SLV_RD[31:24]=0xC3; slave 3 acks: RBCP_RD=0xC3 with RBCP_ACK.
REQ-022 Read addr 0x1000_0000 (unmapped): no SLV strobe; RBCP_ACK next cycle with RD=0x00; ERR pulse.
REQ-023 Timeout (macro defined, TIMEOUT=4), slave 0 silent:
- RBCP_ACK with RD=0x00 and ERR after 4 WAIT cycles;
- a slave 2 ACK during WAIT is ignored.
REQ-024 Protocol corners:
- Strobe during WAIT: dropped, exactly one RBCP_ACK.
- RST asserted in WAIT: BUSY=0 next cycle, no RBCP_ACK.
- Simultaneous WE and RE: treated as a write.

Source files
------------

// File: rtl/rbcp_arb_pkg.sv
// Shared types and constants for the RBCP slave arbiter.
package rbcp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int         NUM_SLV     = 4;
  localparam logic [7:0] UNMAPPED_RD = 8'h00;

endpackage

// File: rtl/rbcp_arb_timer.sv
// WAIT-state watchdog: loads a cycle budget, counts down, flags the last cycle.
module rbcp_arb_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the cycle whose decrement brings the count to zero.
  assign zero = (cnt_q <= 8'd1);

endmodule

// File: rtl/rbcp_arbiter.sv
// RBCP host-to-slave arbiter: decodes a 2-bit slave select, issues one-hot strobes,
// returns the selected slave's acknowledge. Optional WAIT timeout under RBCP_ARB_TIMEOUT_EN.
// Handshake: RBCP_WE/RBCP_RE are accepted only in IDLE; every accepted strobe yields
// exactly one RBCP_ACK pulse (unless aborted by RST), and RBCP_RD is valid with it.
module rbcp_arbiter
  import rbcp_arb_pkg::*;
#(
  parameter int         SEL_LSB = 24,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          RBCP_ADDR,
  input  logic [7:0]           RBCP_WD,
  input  logic                 RBCP_WE,
  input  logic                 RBCP_RE,
  output logic                 RBCP_ACK,
  output logic [7:0]           RBCP_RD,
  output logic [31:0]          SLV_ADDR,
  output logic [7:0]           SLV_WD,
  output logic [NUM_SLV-1:0]   SLV_WE,
  output logic [NUM_SLV-1:0]   SLV_RE,
  input  logic [NUM_SLV-1:0]   SLV_ACK,
  input  logic [8*NUM_SLV-1:0] SLV_RD,
  output logic                 BUSY,
  output logic                 ERR
);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          wd_q, wd_d;
  logic                we_q, we_d;
  logic [1:0]          sel_q, sel_d;
  logic [NUM_SLV-1:0]  slv_we_q, slv_we_d;
  logic [NUM_SLV-1:0]  slv_re_q, slv_re_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [7:0]          rd_q, rd_d;
  logic                busy_q, busy_d;

  logic [1:0]          sel_in;
  logic [NUM_SLV-1:0]  sel_onehot;
  logic                mapped;
  logic                sel_ack;
  logic [7:0]          sel_rd;
  logic                expire;

  assign sel_in     = RBCP_ADDR[SEL_LSB +: 2];
  assign sel_onehot = NUM_SLV'(1) << sel_in;
  assign mapped     = (RBCP_ADDR[31:SEL_LSB+2] == '0);
  assign sel_ack    = SLV_ACK[sel_q];
  assign sel_rd     = SLV_RD[{sel_q, 3'b000} +: 8];

`ifdef RBCP_ARB_TIMEOUT_EN
  rbcp_arb_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (state_q == ST_ISSUE),
    .dec      (state_q == ST_WAIT),
    .load_val (TIMEOUT),
    .zero     (expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    we_d     = we_q;
    sel_d    = sel_q;
    slv_we_d = '0;
    slv_re_d = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (RBCP_WE || RBCP_RE) begin
          addr_d = RBCP_ADDR;
          wd_d   = RBCP_WD;
          we_d   = RBCP_WE;
          sel_d  = sel_in;
          if (!mapped) begin
            rd_d    = UNMAPPED_RD;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            // Strobe is registered here so it is visible during the ISSUE cycle.
            if (RBCP_WE) slv_we_d = sel_onehot;
            else         slv_re_d = sel_onehot;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sel_ack) begin
          rd_d    = we_q ? 8'h00 : sel_rd;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (expire) begin
          rd_d    = UNMAPPED_RD;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      wd_q     <= 8'd0;
      we_q     <= 1'b0;
      sel_q    <= 2'd0;
      slv_we_q <= '0;
      slv_re_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      slv_we_q <= slv_we_d;
      slv_re_q <= slv_re_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
    end
  end

  assign RBCP_ACK = ack_q;
  assign RBCP_RD  = rd_q;
  assign SLV_ADDR = addr_q;
  assign SLV_WD   = wd_q;
  assign SLV_WE   = slv_we_q;
  assign SLV_RE   = slv_re_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_rbcp_arbiter.sv
// Directed bench for rbcp_arbiter; timeout scenario depends on RBCP_ARB_TIMEOUT_EN.
module tb_rbcp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic        rbcp_we;
  logic        rbcp_re;
  logic        rbcp_ack;
  logic [7:0]  rbcp_rd;
  logic [31:0] slv_addr;
  logic [7:0]  slv_wd;
  logic [3:0]  slv_we;
  logic [3:0]  slv_re;
  logic [3:0]  slv_ack;
  logic [31:0] slv_rd;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd;

  always #5 clk = ~clk;

  rbcp_arbiter #(.SEL_LSB(24), .TIMEOUT(8'd4)) dut (
    .CLK(clk), .RST(rst), .RBCP_ADDR(rbcp_addr), .RBCP_WD(rbcp_wd),
    .RBCP_WE(rbcp_we), .RBCP_RE(rbcp_re), .RBCP_ACK(rbcp_ack), .RBCP_RD(rbcp_rd),
    .SLV_ADDR(slv_addr), .SLV_WD(slv_wd), .SLV_WE(slv_we), .SLV_RE(slv_re),
    .SLV_ACK(slv_ack), .SLV_RD(slv_rd), .BUSY(busy), .ERR(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a one-cycle host strobe; returns in the cycle after it was sampled.
  task automatic drive_strobe(input logic we, input logic re,
                              input logic [31:0] addr, input logic [7:0] wd);
    rbcp_we = we; rbcp_re = re; rbcp_addr = addr; rbcp_wd = wd;
    step();
    rbcp_we = 1'b0; rbcp_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (rbcp_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h exp 0", rbcp_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err); end
    checks++; if (slv_we !== 4'b0000 || slv_re !== 4'b0000) begin errors++; $display("FAIL reset_strobes got we=%0h re=%0h exp 0", slv_we, slv_re); end
    checks++; if (rbcp_rd !== 8'h00) begin errors++; $display("FAIL reset_rd got %0h exp 00", rbcp_rd); end
    checks++; if (slv_addr !== 32'h0 || slv_wd !== 8'h00) begin errors++; $display("FAIL reset_latch got addr=%0h wd=%0h exp 0", slv_addr, slv_wd); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    exp_q.push_back(8'h00);
    drive_strobe(1'b1, 1'b0, 32'h0100_0010, 8'h5A);
    checks++; if (slv_we !== 4'b0010) begin errors++; $display("FAIL wr_slv_we got %b exp 0010", slv_we); end
    checks++; if (slv_re !== 4'b0000) begin errors++; $display("FAIL wr_slv_re got %b exp 0000", slv_re); end
    checks++; if (slv_wd !== 8'h5A || slv_addr !== 32'h0100_0010) begin errors++; $display("FAIL wr_latch got addr=%0h wd=%0h exp 01000010/5a", slv_addr, slv_wd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0h exp 1", busy); end
    step();
    checks++; if (slv_we !== 4'b0000) begin errors++; $display("FAIL wr_strobe_len got %b exp 0000", slv_we); end
    step();
    slv_ack = 4'b0010;
    step();
    slv_ack = 4'b0000;
    exp_rd = exp_q.pop_front();
    checks++; if (rbcp_ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%0h err=%0h exp 1/0", rbcp_ack, err); end
    checks++; if (rbcp_rd !== exp_rd) begin errors++; $display("FAIL wr_rd got %0h exp %0h", rbcp_rd, exp_rd); end
    checks++; if (slv_wd !== 8'h5A) begin errors++; $display("FAIL wr_wd_stable got %0h exp 5a", slv_wd); end
    step();
    checks++; if (rbcp_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_done got ack=%0h busy=%0h exp 0/0", rbcp_ack, busy); end
  endtask

  task automatic test_read();
    slv_rd = 32'hC311_2233;
    exp_q.push_back(8'hC3);
    drive_strobe(1'b0, 1'b1, 32'h0300_0000, 8'h00);
    checks++; if (slv_re !== 4'b1000 || slv_we !== 4'b0000) begin errors++; $display("FAIL rd3_strobe got re=%b we=%b exp 1000/0000", slv_re, slv_we); end
    step();
    slv_ack = 4'b1000;
    step();
    slv_ack = 4'b0000;
    exp_rd = exp_q.pop_front();
    checks++; if (rbcp_ack !== 1'b1 || rbcp_rd !== exp_rd || err !== 1'b0) begin errors++; $display("FAIL rd3_data got ack=%0h rd=%0h err=%0h exp 1/%0h/0", rbcp_ack, rbcp_rd, err, exp_rd); end
    step();
    checks++; if (rbcp_ack !== 1'b0 || rbcp_rd !== 8'hC3) begin errors++; $display("FAIL rd3_hold got ack=%0h rd=%0h exp 0/c3", rbcp_ack, rbcp_rd); end
    exp_q.push_back(8'h22);
    drive_strobe(1'b0, 1'b1, 32'h0100_0000, 8'h00);
    checks++; if (slv_re !== 4'b0010) begin errors++; $display("FAIL rd1_strobe got %b exp 0010", slv_re); end
    step();
    slv_ack = 4'b0010;
    step();
    slv_ack = 4'b0000;
    exp_rd = exp_q.pop_front();
    checks++; if (rbcp_ack !== 1'b1 || rbcp_rd !== exp_rd) begin errors++; $display("FAIL rd1_data got ack=%0h rd=%0h exp 1/%0h", rbcp_ack, rbcp_rd, exp_rd); end
    step();
  endtask

  task automatic test_both_strobes();
    drive_strobe(1'b1, 1'b1, 32'h0100_0000, 8'hA5);
    checks++; if (slv_we !== 4'b0010 || slv_re !== 4'b0000) begin errors++; $display("FAIL both_dir got we=%b re=%b exp 0010/0000", slv_we, slv_re); end
    step();
    slv_ack = 4'b0010;
    step();
    slv_ack = 4'b0000;
    checks++; if (rbcp_ack !== 1'b1 || rbcp_rd !== 8'h00) begin errors++; $display("FAIL both_rd got ack=%0h rd=%0h exp 1/00", rbcp_ack, rbcp_rd); end
    step();
  endtask

  task automatic test_timeout();
    int n;
`ifdef RBCP_ARB_TIMEOUT_EN
    drive_strobe(1'b0, 1'b1, 32'h0000_0000, 8'h00);
    checks++; if (slv_re !== 4'b0001) begin errors++; $display("FAIL to_strobe got %b exp 0001", slv_re); end
    step(); step(); step(); step();
    slv_ack = 4'b0001;
    step();
    slv_ack = 4'b0000;
    checks++; if (rbcp_ack !== 1'b1 || err !== 1'b0 || rbcp_rd !== 8'h33) begin errors++; $display("FAIL to_ack_at_expiry got ack=%0h err=%0h rd=%0h exp 1/0/33", rbcp_ack, err, rbcp_rd); end
    step();
    drive_strobe(1'b0, 1'b1, 32'h0000_0000, 8'h00);
    slv_ack = 4'b0100;
    n = 0;
    step();
    while (rbcp_ack !== 1'b1 && n < 20) begin n++; step(); end
    slv_ack = 4'b0000;
    checks++; if (n !== 4) begin errors++; $display("FAIL to_wait_cycles got %0d exp 4", n); end
    checks++; if (rbcp_ack !== 1'b1 || err !== 1'b1 || rbcp_rd !== 8'h00) begin errors++; $display("FAIL to_resp got ack=%0h err=%0h rd=%0h exp 1/1/00", rbcp_ack, err, rbcp_rd); end
    step();
    checks++; if (err !== 1'b0 || rbcp_ack !== 1'b0) begin errors++; $display("FAIL to_pulse got err=%0h ack=%0h exp 0/0", err, rbcp_ack); end
`else
    drive_strobe(1'b0, 1'b1, 32'h0000_0000, 8'h00);
    checks++; if (slv_re !== 4'b0001) begin errors++; $display("FAIL nto_strobe got %b exp 0001", slv_re); end
    slv_ack = 4'b0100;
    n = 0;
    repeat (12) begin step(); if (rbcp_ack === 1'b1 || err === 1'b1) n++; end
    checks++; if (n !== 0 || busy !== 1'b1) begin errors++; $display("FAIL nto_hold got acks=%0d busy=%0h exp 0/1", n, busy); end
    slv_ack = 4'b0001;
    step();
    slv_ack = 4'b0000;
    checks++; if (rbcp_ack !== 1'b1 || err !== 1'b0 || rbcp_rd !== 8'h33) begin errors++; $display("FAIL nto_ack got ack=%0h err=%0h rd=%0h exp 1/0/33", rbcp_ack, err, rbcp_rd); end
    step();
`endif
  endtask

  task automatic test_unmapped();
    drive_strobe(1'b0, 1'b1, 32'h1000_0000, 8'h00);
    checks++; if (rbcp_ack !== 1'b1 || err !== 1'b1 || rbcp_rd !== 8'h00) begin errors++; $display("FAIL unm_resp got ack=%0h err=%0h rd=%0h exp 1/1/00", rbcp_ack, err, rbcp_rd); end
    checks++; if (slv_re !== 4'b0000 || slv_we !== 4'b0000) begin errors++; $display("FAIL unm_strobe got re=%b we=%b exp 0", slv_re, slv_we); end
    step();
    checks++; if (rbcp_ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL unm_done got ack=%0h err=%0h busy=%0h exp 0/0/0", rbcp_ack, err, busy); end
  endtask

  task automatic test_strobe_in_wait();
    int acks;
    drive_strobe(1'b1, 1'b0, 32'h0200_0004, 8'h3C);
    checks++; if (slv_we !== 4'b0100) begin errors++; $display("FAIL siw_strobe got %b exp 0100", slv_we); end
    step();
    rbcp_re = 1'b1; rbcp_addr = 32'h0300_0000;
    step();
    rbcp_re = 1'b0;
    checks++; if (slv_re !== 4'b0000 || slv_addr !== 32'h0200_0004 || busy !== 1'b1) begin errors++; $display("FAIL siw_drop got re=%b addr=%0h busy=%0h exp 0000/02000004/1", slv_re, slv_addr, busy); end
    slv_ack = 4'b0100;
    step();
    slv_ack = 4'b0000;
    acks = (rbcp_ack === 1'b1) ? 1 : 0;
    repeat (6) begin step(); if (rbcp_ack === 1'b1) acks++; end
    checks++; if (acks !== 1 || busy !== 1'b0) begin errors++; $display("FAIL siw_acks got acks=%0d busy=%0h exp 1/0", acks, busy); end
  endtask

  task automatic test_reset_in_wait();
    drive_strobe(1'b0, 1'b1, 32'h0100_0000, 8'h00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rbcp_ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL riw_abort got busy=%0h ack=%0h err=%0h exp 0/0/0", busy, rbcp_ack, err); end
    checks++; if (slv_addr !== 32'h0) begin errors++; $display("FAIL riw_addr got %0h exp 0", slv_addr); end
    slv_ack = 4'b0010;
    step();
    slv_ack = 4'b0000;
    checks++; if (rbcp_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL riw_after got ack=%0h busy=%0h exp 0/0", rbcp_ack, busy); end
  endtask

  initial begin
    rst = 1'b1; rbcp_addr = 32'h0; rbcp_wd = 8'h00; rbcp_we = 1'b0; rbcp_re = 1'b0;
    slv_ack = 4'b0000; slv_rd = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_both_strobes();
    test_timeout();
    test_unmapped();
    test_strobe_in_wait();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
